// File: rtl/hazard_unit_multi.sv
// hazard_unit_multi: DEPTH-deep scoreboard giving registered forward selects and a load-use stall; HAZARD_PERF_EN adds a stall counter
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef LOAD
`define LOAD 7'b0000011
`endif
module hazard_unit_multi #(
   parameter int AWIDTH = 5,
   parameter int DEPTH = 3,
   parameter int LOAD_STAGE = 2,
   localparam int FW = $clog2(DEPTH + 1)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     ds_i_valid,
   input  logic [`OPCODE_WIDTH-1:0] ds_i_opcode,
   input  logic [AWIDTH-1:0]        ds_i_addr_rs1,
   input  logic [AWIDTH-1:0]        ds_i_addr_rs2,
   input  logic [AWIDTH-1:0]        ds_i_addr_rd,
   input  logic                     ds_i_regwrite,
   input  logic                     i_flush,
   input  logic                     i_hold,
   output logic                     f_o_stall,
   output logic [FW-1:0]            f_o_control_rs1,
   output logic [FW-1:0]            f_o_control_rs2
`ifdef HAZARD_PERF_EN
   ,
   output logic [15:0]              f_o_stall_cnt
`endif
);
   logic [DEPTH-1:0]  trk_v;
   logic [DEPTH-1:0]  trk_ld;
   logic [AWIDTH-1:0] trk_rd [DEPTH];
   logic [FW-1:0]     sel1, sel2;
   logic              haz1, haz2, issue;

   // youngest-match lookup: scan oldest to youngest so the smallest j wins
   always_comb begin
      sel1 = '0;
      sel2 = '0;
      haz1 = 1'b0;
      haz2 = 1'b0;
      for (int j = DEPTH - 1; j >= 0; j--) begin
         if (trk_v[j] && trk_rd[j] == ds_i_addr_rs1 && ds_i_addr_rs1 != '0) begin
            sel1 = FW'(j + 1);
            haz1 = (j + 1) < (trk_ld[j] ? LOAD_STAGE : 1);
         end
         if (trk_v[j] && trk_rd[j] == ds_i_addr_rs2 && ds_i_addr_rs2 != '0) begin
            sel2 = FW'(j + 1);
            haz2 = (j + 1) < (trk_ld[j] ? LOAD_STAGE : 1);
         end
      end
   end

   assign f_o_stall = ds_i_valid & ~i_flush & (haz1 | haz2);
   assign issue     = ds_i_valid & ~i_flush & ~f_o_stall;

   // scoreboard shift and select registers; flushes and stalls enter EX as bubbles
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         trk_v           <= '0;
         trk_ld          <= '0;
         for (int j = 0; j < DEPTH; j++) trk_rd[j] <= '0;
         f_o_control_rs1 <= '0;
         f_o_control_rs2 <= '0;
      end else if (!i_hold) begin
         for (int j = 1; j < DEPTH; j++) begin
            trk_v[j]  <= trk_v[j-1];
            trk_ld[j] <= trk_ld[j-1];
            trk_rd[j] <= trk_rd[j-1];
         end
         trk_v[0]        <= issue & ds_i_regwrite & (ds_i_addr_rd != '0);
         trk_ld[0]       <= ds_i_opcode == `LOAD;
         trk_rd[0]       <= ds_i_addr_rd;
         f_o_control_rs1 <= issue ? sel1 : '0;
         f_o_control_rs2 <= issue ? sel2 : '0;
      end
   end

`ifdef HAZARD_PERF_EN
   // saturating count of stall cycles that actually cost an edge
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) f_o_stall_cnt <= '0;
      else if (f_o_stall && !i_hold && f_o_stall_cnt != 16'hFFFF) f_o_stall_cnt <= f_o_stall_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_hazard_unit_multi.sv
// tb_hazard_unit_multi: directed checks of forwarding, load-use stall, flush, hold, reset and stall counter
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef LOAD
`define LOAD 7'b0000011
`endif
module tb_hazard_unit_multi;
   localparam logic [`OPCODE_WIDTH-1:0] ALU = 7'b0110011;
   logic i_clk = 0, i_rst = 1, ds_i_valid = 0, ds_i_regwrite = 0, i_flush = 0, i_hold = 0;
   logic [`OPCODE_WIDTH-1:0] ds_i_opcode = ALU;
   logic [4:0] ds_i_addr_rs1 = 0, ds_i_addr_rs2 = 0, ds_i_addr_rd = 0;
   logic f_o_stall, stall3;
   logic [1:0] c1, c2, c1_3, c2_3;
`ifdef HAZARD_PERF_EN
   logic [15:0] cnt, cnt3;
`endif
   int pass = 0, total = 0;

   hazard_unit_multi dut (
      .i_clk(i_clk), .i_rst(i_rst), .ds_i_valid(ds_i_valid), .ds_i_opcode(ds_i_opcode),
      .ds_i_addr_rs1(ds_i_addr_rs1), .ds_i_addr_rs2(ds_i_addr_rs2), .ds_i_addr_rd(ds_i_addr_rd),
      .ds_i_regwrite(ds_i_regwrite), .i_flush(i_flush), .i_hold(i_hold),
      .f_o_stall(f_o_stall), .f_o_control_rs1(c1), .f_o_control_rs2(c2)
`ifdef HAZARD_PERF_EN
      , .f_o_stall_cnt(cnt)
`endif
   );

   hazard_unit_multi #(.LOAD_STAGE(3)) dut3 (
      .i_clk(i_clk), .i_rst(i_rst), .ds_i_valid(ds_i_valid), .ds_i_opcode(ds_i_opcode),
      .ds_i_addr_rs1(ds_i_addr_rs1), .ds_i_addr_rs2(ds_i_addr_rs2), .ds_i_addr_rd(ds_i_addr_rd),
      .ds_i_regwrite(ds_i_regwrite), .i_flush(i_flush), .i_hold(i_hold),
      .f_o_stall(stall3), .f_o_control_rs1(c1_3), .f_o_control_rs2(c2_3)
`ifdef HAZARD_PERF_EN
      , .f_o_stall_cnt(cnt3)
`endif
   );

   always #5 i_clk = ~i_clk;

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic ld, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd, input logic rw);
      ds_i_valid = v;
      ds_i_opcode = ld ? `LOAD : ALU;
      ds_i_addr_rs1 = a1;
      ds_i_addr_rs2 = a2;
      ds_i_addr_rd = rd;
      ds_i_regwrite = rw;
      #1;
   endtask

   task automatic idle(input int n);
      drv(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      i_rst = 1;
      drv(1, 0, 3, 4, 5, 1);
      total++; if (f_o_stall !== 1'b0) $display("FAIL reset_stall: got %0d want 0", f_o_stall); else pass++;
      total++; if (c1 !== 2'd0 || c2 !== 2'd0) $display("FAIL reset_sel: got %0d/%0d want 0/0", c1, c2); else pass++;
      total++; if (c1_3 !== 2'd0 || stall3 !== 1'b0) $display("FAIL reset_dut3: got sel %0d stall %0d want 0 0", c1_3, stall3); else pass++;
`ifdef HAZARD_PERF_EN
      total++; if (cnt !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", cnt); else pass++;
`endif
      drv(0, 0, 0, 0, 0, 0);
      @(negedge i_clk);
      i_rst = 0;
      step();
   endtask

   task automatic test_alu_chain();
      drv(1, 0, 1, 2, 8, 1);
      step();
      drv(1, 0, 8, 3, 10, 1);
      total++; if (f_o_stall !== 1'b0) $display("FAIL alu_stall: got %0d want 0", f_o_stall); else pass++;
      step();
      total++; if (c1 !== 2'd1 || c2 !== 2'd0) $display("FAIL alu_sel1: got %0d/%0d want 1/0", c1, c2); else pass++;
      drv(1, 0, 11, 8, 12, 1);
      total++; if (f_o_stall !== 1'b0) $display("FAIL alu_stall2: got %0d want 0", f_o_stall); else pass++;
      step();
      total++; if (c1 !== 2'd0 || c2 !== 2'd2) $display("FAIL alu_sel2: got %0d/%0d want 0/2", c1, c2); else pass++;
      idle(4);
   endtask

   task automatic test_load_use();
      drv(1, 1, 0, 0, 9, 1);
      step();
      drv(1, 0, 9, 9, 13, 1);
      total++; if (f_o_stall !== 1'b1) $display("FAIL lu_stall: got %0d want 1", f_o_stall); else pass++;
      step();
      total++; if (c1 !== 2'd0 || c2 !== 2'd0) $display("FAIL lu_bubble: got %0d/%0d want 0/0", c1, c2); else pass++;
      total++; if (f_o_stall !== 1'b0) $display("FAIL lu_stall_end: got %0d want 0", f_o_stall); else pass++;
      step();
      total++; if (c1 !== 2'd2 || c2 !== 2'd2) $display("FAIL lu_sel: got %0d/%0d want 2/2", c1, c2); else pass++;
      idle(4);
   endtask

   task automatic test_load_stage3();
      drv(1, 1, 0, 0, 9, 1);
      step();
      drv(1, 0, 9, 9, 13, 1);
      total++; if (stall3 !== 1'b1) $display("FAIL ls3_stall_a: got %0d want 1", stall3); else pass++;
      step();
      total++; if (stall3 !== 1'b1) $display("FAIL ls3_stall_b: got %0d want 1", stall3); else pass++;
      step();
      total++; if (stall3 !== 1'b0) $display("FAIL ls3_stall_end: got %0d want 0", stall3); else pass++;
      total++; if (c1_3 !== 2'd0 || c2_3 !== 2'd0) $display("FAIL ls3_bubble: got %0d/%0d want 0/0", c1_3, c2_3); else pass++;
      step();
      total++; if (c1_3 !== 2'd3 || c2_3 !== 2'd3) $display("FAIL ls3_sel: got %0d/%0d want 3/3", c1_3, c2_3); else pass++;
      idle(4);
   endtask

   task automatic test_youngest();
      drv(1, 0, 0, 0, 5, 1);
      step();
      drv(1, 0, 0, 0, 5, 1);
      step();
      drv(1, 0, 5, 0, 6, 1);
      step();
      total++; if (c1 !== 2'd1) $display("FAIL young_alu: got %0d want 1", c1); else pass++;
      idle(4);
      drv(1, 1, 0, 0, 5, 1);
      step();
      drv(1, 0, 0, 0, 5, 1);
      step();
      drv(1, 0, 5, 0, 7, 1);
      total++; if (f_o_stall !== 1'b0) $display("FAIL young_ld_stall: got %0d want 0", f_o_stall); else pass++;
      step();
      total++; if (c1 !== 2'd1) $display("FAIL young_ld_sel: got %0d want 1", c1); else pass++;
      idle(4);
   endtask

   task automatic test_reg0();
      drv(1, 0, 0, 0, 0, 1);
      step();
      drv(1, 0, 0, 0, 6, 1);
      total++; if (f_o_stall !== 1'b0) $display("FAIL r0_stall: got %0d want 0", f_o_stall); else pass++;
      step();
      total++; if (c1 !== 2'd0 || c2 !== 2'd0) $display("FAIL r0_sel: got %0d/%0d want 0/0", c1, c2); else pass++;
      idle(4);
      drv(1, 1, 0, 0, 0, 1);
      step();
      drv(1, 0, 0, 0, 6, 1);
      total++; if (f_o_stall !== 1'b0) $display("FAIL r0_ld_stall: got %0d want 0", f_o_stall); else pass++;
      idle(4);
   endtask

   task automatic test_flush_hold();
      drv(1, 1, 0, 0, 4, 1);
      step();
      i_flush = 1;
      drv(1, 0, 4, 0, 15, 1);
      total++; if (f_o_stall !== 1'b0) $display("FAIL fl_stall: got %0d want 0", f_o_stall); else pass++;
      step();
      i_flush = 0;
      total++; if (c1 !== 2'd0) $display("FAIL fl_bubble: got %0d want 0", c1); else pass++;
      drv(1, 0, 1, 15, 16, 1);
      step();
      total++; if (c2 !== 2'd0) $display("FAIL fl_no_fwd: got %0d want 0", c2); else pass++;
      idle(4);
      drv(1, 0, 0, 0, 20, 1);
      step();
      drv(1, 0, 20, 0, 21, 1);
      step();
      total++; if (c1 !== 2'd1) $display("FAIL hold_pre: got %0d want 1", c1); else pass++;
      i_hold = 1;
      drv(1, 0, 21, 20, 22, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (c1 !== 2'd1 || c2 !== 2'd0) $display("FAIL hold_frozen%0d: got %0d/%0d want 1/0", i, c1, c2); else pass++;
      end
      i_hold = 0;
      #1;
      step();
      total++; if (c1 !== 2'd1 || c2 !== 2'd2) $display("FAIL hold_resume: got %0d/%0d want 1/2", c1, c2); else pass++;
      idle(4);
   endtask

   task automatic test_counter();
`ifdef HAZARD_PERF_EN
      i_rst = 1;
      #2;
      i_rst = 0;
      #1;
      for (int i = 0; i < 10; i++) begin
         drv(1, 1, 0, 0, 9, 1);
         step();
         drv(1, 0, 9, 9, 13, 1);
         step();
         step();
      end
      total++; if (cnt !== 16'd10) $display("FAIL cnt_10: got %0d want 10", cnt); else pass++;
      idle(4);
`endif
   endtask

   task automatic test_reset_mid_stall();
      drv(1, 1, 0, 0, 9, 1);
      step();
      drv(1, 0, 9, 9, 13, 1);
      total++; if (f_o_stall !== 1'b1) $display("FAIL rms_pre: got %0d want 1", f_o_stall); else pass++;
      i_rst = 1;
      #1;
      total++; if (f_o_stall !== 1'b0) $display("FAIL rms_stall: got %0d want 0", f_o_stall); else pass++;
      total++; if (c1 !== 2'd0 || c2 !== 2'd0) $display("FAIL rms_sel: got %0d/%0d want 0/0", c1, c2); else pass++;
`ifdef HAZARD_PERF_EN
      total++; if (cnt !== 16'd0) $display("FAIL rms_cnt: got %0d want 0", cnt); else pass++;
`endif
      @(negedge i_clk);
      i_rst = 0;
      step();
      total++; if (c1 !== 2'd0 || c2 !== 2'd0) $display("FAIL rms_issue_sel: got %0d/%0d want 0/0", c1, c2); else pass++;
      drv(1, 0, 13, 0, 14, 1);
      step();
      total++; if (c1 !== 2'd1) $display("FAIL rms_issued: got %0d want 1", c1); else pass++;
      idle(4);
   endtask

   initial begin
      test_reset();
      test_alu_chain();
      test_load_use();
      test_load_stage3();
      test_youngest();
      test_reg0();
      test_flush_hold();
      test_counter();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
